// File: rtl/vga_scan_compositor.sv
// VGA scan compositor: pixel counters, delayed timing decode and final
// sync/rgb output register aligned with the pipelined overlay pixels.
module vga_scan_compositor #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIPE_LAT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] vga_h,
  output logic [10:0] vga_v,
  input  logic [2:0]  overlay_pixel,
  input  logic        overlay_on,
  input  logic [2:0]  bg_pixel,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  rgb,
  output logic        active,
  output logic        frame_start
);

  localparam logic [10:0] H_TOTAL =
    11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [10:0] V_TOTAL =
    11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END =
    11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END =
    11'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
  } tdec_t;

  tdec_t dec;
  tdec_t tap;
  tdec_t dly [PIPE_LAT];

  if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_lat_chk
    $error("PIPE_LAT must be in 1..4");
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_h <= '0;
      vga_v <= '0;
    end else if (vga_h == H_TOTAL - 11'd1) begin
      vga_h <= '0;
      if (vga_v == V_TOTAL - 11'd1)
        vga_v <= '0;
      else
        vga_v <= vga_v + 11'd1;
    end else begin
      vga_h <= vga_h + 11'd1;
    end
  end

  always_comb begin
    dec     = '0;
    dec.hs  = (vga_h >= HS_BEG) && (vga_h < HS_END);
    dec.vs  = (vga_v >= VS_BEG) && (vga_v < VS_END);
    dec.act = (vga_h < H_VIS) && (vga_v < V_VIS);
    dec.fs  = (vga_h == '0) && (vga_v == '0);
  end

  // delay matches the overlay chain so syncs line up with pixels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++)
        dly[i] <= '0;
    end else begin
      dly[0] <= dec;
      for (int i = 1; i < PIPE_LAT; i++)
        dly[i] <= dly[i-1];
    end
  end

  assign tap = dly[PIPE_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb         <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
    end else begin
      if (!tap.act)
        rgb <= '0;
      else if (overlay_on)
        rgb <= overlay_pixel;
      else
        rgb <= bg_pixel;
      active      <= tap.act;
      frame_start <= tap.fs;
      hsync       <= tap.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= tap.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Directed bench: full-size timing on one instance, small-geometry
// frames at PIPE_LAT 2 and 1 on two more, shared clock and reset.
module tb_vga_scan_compositor;

  logic clk;
  logic reset;
  bit   mode;
  int   checks;
  int   errors;
  int   e;

  logic [10:0] d_h, d_v, a_h, a_v, b_h, b_v;
  logic        d_hs, d_vs, d_act, d_fs;
  logic        a_hs, a_vs, a_act, a_fs;
  logic        b_hs, b_vs, b_act, b_fs;
  logic [2:0]  d_rgb, a_rgb, b_rgb;
  logic [3:0]  pa0, pa1, pb0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_scan_compositor u_def (
    .clk(clk), .reset(reset),
    .vga_h(d_h), .vga_v(d_v),
    .overlay_pixel(3'b111), .overlay_on(1'b0),
    .bg_pixel(3'b010),
    .hsync(d_hs), .vsync(d_vs), .rgb(d_rgb),
    .active(d_act), .frame_start(d_fs)
  );

  vga_scan_compositor #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(18), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .PIPE_LAT(2)
  ) u_sm2 (
    .clk(clk), .reset(reset),
    .vga_h(a_h), .vga_v(a_v),
    .overlay_pixel(pa1[2:0]), .overlay_on(pa1[3]),
    .bg_pixel(3'b001),
    .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb),
    .active(a_act), .frame_start(a_fs)
  );

  vga_scan_compositor #(
    .H_VISIBLE(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(18), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .PIPE_LAT(1)
  ) u_sm1 (
    .clk(clk), .reset(reset),
    .vga_h(b_h), .vga_v(b_v),
    .overlay_pixel(pb0[2:0]), .overlay_on(pb0[3]),
    .bg_pixel(3'b001),
    .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb),
    .active(b_act), .frame_start(b_fs)
  );

  // overlay source model: {on, pixel}, box at h,v in 11..15
  function automatic logic [3:0] ovl(
    input logic [10:0] h, input logic [10:0] v, input bit m);
    bit on;
    if (m) return 4'b1111;
    on = (h >= 11) && (h <= 15) && (v >= 11) && (v <= 15);
    return on ? 4'b1100 : 4'b0110;
  endfunction

  always @(posedge clk) begin
    pa0 <= ovl(a_h, a_v, mode);
    pa1 <= pa0;
    pb0 <= ovl(b_h, b_v, mode);
  end

  // {rgb, active, hsync, vsync, frame_start} for 640x480 timing
  function automatic logic [6:0] exp_def(input int ed);
    int p, h, v;
    logic act;
    p = ed - 3;
    if (p < 0) return 7'b000_0_1_1_0;
    h = p % 800;
    v = (p / 800) % 525;
    act = (h < 640) && (v < 480);
    return {act ? 3'b010 : 3'b000, act,
            !(h >= 656 && h < 752),
            !(v >= 490 && v < 492),
            (h == 0) && (v == 0)};
  endfunction

  // same for the 28x23 geometry, latency lat
  function automatic logic [6:0] exp_sm(
    input int ed, input int lat, input bit m);
    int p, h, v;
    logic act, box;
    logic [2:0] px;
    p = ed - lat - 1;
    if (p < 0) return 7'b000_0_1_1_0;
    h = p % 28;
    v = (p / 28) % 23;
    act = (h < 20) && (v < 18);
    box = (h >= 11) && (h <= 15) && (v >= 11) && (v <= 15);
    px = m ? 3'b111 : (box ? 3'b100 : 3'b001);
    return {act ? px : 3'b000, act,
            !(h >= 22 && h < 25),
            !(v >= 19 && v < 21),
            (h == 0) && (v == 0)};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  int d_cnt_bad, d_out_bad, d_hs_low, d_hs_first;
  int a_cnt_bad, a_out_bad, b_cnt_bad, b_out_bad;
  int a_ovl, a_vslow, a_fscnt, a_fs_first, b_fs_first;
  int a_hs_first, b_hs_first, a_blank, a_vis;

  initial begin
    checks = 0; errors = 0; e = 0; mode = 1'b0;
    d_cnt_bad = 0; d_out_bad = 0; d_hs_low = 0;
    d_hs_first = -1; a_cnt_bad = 0; a_out_bad = 0;
    b_cnt_bad = 0; b_out_bad = 0; a_ovl = 0;
    a_vslow = 0; a_fscnt = 0; a_fs_first = -1;
    b_fs_first = -1; a_hs_first = -1; b_hs_first = -1;
    a_blank = 0; a_vis = 0;

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_rgb", 32'(d_rgb), 0);
    chk("rst_active", 32'(d_act), 0);
    chk("rst_hsync", 32'(d_hs), 1);
    chk("rst_vsync", 32'(d_vs), 1);
    chk("rst_fs", 32'(d_fs), 0);
    chk("rst_h", 32'(d_h), 0);

    @(negedge clk);
    reset = 1'b0;
    e = 0;
    #1;
    chk("rel_h", 32'(d_h), 0);
    chk("rel_v", 32'(d_v), 0);

    while (!(e >= 2000 && e % 644 == 153)) begin
      tick();
      if (int'(d_h) != e % 800 ||
          int'(d_v) != (e / 800) % 525) d_cnt_bad++;
      if ({d_rgb, d_act, d_hs, d_vs, d_fs} !== exp_def(e))
        d_out_bad++;
      if (e <= 803 && d_hs == 1'b0) begin
        d_hs_low++;
        if (d_hs_first < 0) d_hs_first = e;
      end
      if (e == 1) chk("step1_h", 32'(d_h), 1);
      if (e == 800) begin
        chk("wrap_h", 32'(d_h), 0);
        chk("wrap_v", 32'(d_v), 1);
      end
      if (int'(a_h) != e % 28 ||
          int'(a_v) != (e / 28) % 23) a_cnt_bad++;
      if (int'(b_h) != e % 28 ||
          int'(b_v) != (e / 28) % 23) b_cnt_bad++;
      if ({a_rgb, a_act, a_hs, a_vs, a_fs} !== exp_sm(e, 2, 0))
        a_out_bad++;
      if ({b_rgb, b_act, b_hs, b_vs, b_fs} !== exp_sm(e, 1, 0))
        b_out_bad++;
      if (e >= 3 && e < 3 + 644) begin
        if (a_rgb == 3'b100) a_ovl++;
        if (a_vs == 1'b0) a_vslow++;
        if (a_fs == 1'b1) a_fscnt++;
      end
      if (a_fs && a_fs_first < 0) a_fs_first = e;
      if (b_fs && b_fs_first < 0) b_fs_first = e;
      if (!a_hs && a_hs_first < 0) a_hs_first = e;
      if (!b_hs && b_hs_first < 0) b_hs_first = e;
    end

    chk("def_counters", 32'(d_cnt_bad), 0);
    chk("def_outputs", 32'(d_out_bad), 0);
    chk("def_hs_first", 32'(d_hs_first), 659);
    chk("def_hs_width", 32'(d_hs_low), 96);
    chk("sm2_counters", 32'(a_cnt_bad), 0);
    chk("sm1_counters", 32'(b_cnt_bad), 0);
    chk("sm2_outputs", 32'(a_out_bad), 0);
    chk("sm1_outputs", 32'(b_out_bad), 0);
    chk("sm2_ovl_pixels", 32'(a_ovl), 25);
    chk("sm2_vs_width", 32'(a_vslow), 56);
    chk("sm2_fs_count", 32'(a_fscnt), 1);
    chk("sm2_fs_first", 32'(a_fs_first), 3);
    chk("sm1_fs_first", 32'(b_fs_first), 2);
    chk("sm2_hs_first", 32'(a_hs_first), 25);
    chk("sm1_hs_first", 32'(b_hs_first), 24);

    chk("pre_rst_h", 32'(a_h), 13);
    chk("pre_rst_v", 32'(a_v), 5);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_h", 32'(a_h), 0);
    chk("mid_rst_v", 32'(a_v), 0);
    chk("mid_rst_rgb", 32'(a_rgb), 0);
    chk("mid_rst_act", 32'(a_act), 0);
    chk("mid_rst_hs", 32'(a_hs), 1);
    chk("mid_rst_vs", 32'(a_vs), 1);
    chk("mid_rst_def_act", 32'(d_act), 0);

    mode = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    e = 0;
    a_out_bad = 0;
    b_out_bad = 0;
    repeat (660) begin
      tick();
      if ({a_rgb, a_act, a_hs, a_vs, a_fs} !== exp_sm(e, 2, 1))
        a_out_bad++;
      if ({b_rgb, b_act, b_hs, b_vs, b_fs} !== exp_sm(e, 1, 1))
        b_out_bad++;
      if (e >= 3 && e < 3 + 644) begin
        if (!a_act && a_rgb == 3'b000) a_blank++;
        if (a_act && a_rgb == 3'b111) a_vis++;
      end
    end
    chk("full_ovl_sm2", 32'(a_out_bad), 0);
    chk("full_ovl_sm1", 32'(b_out_bad), 0);
    chk("full_ovl_blank", 32'(a_blank), 284);
    chk("full_ovl_vis", 32'(a_vis), 360);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
